// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/LSU memory port arbiter.
// Also provides the width helper for the D-streak counter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_t;
    typedef enum logic {ARB_OWNER_I, ARB_OWNER_D} arb_owner_t;

    function automatic int streak_width(input int max_streak);
        return (max_streak > 1) ? $clog2(max_streak + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and memory buses around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding core and memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import mem_port_arbiter_pkg::*;

    // Handshakes: a request transfers in the cycle where valid and ready are both high;
    // ready may depend combinationally on valid, and rsp_valid is a single-cycle pulse
    // with no back-pressure.
    logic                      i_req_valid;
    logic [ADDR_WIDTH-1:0]     i_req_addr;
    logic                      i_req_ready;
    logic                      i_rsp_valid;
    logic [DATA_WIDTH-1:0]     i_rsp_rdata;

    logic                      d_req_valid;
    logic                      d_req_we;
    logic [ADDR_WIDTH-1:0]     d_req_addr;
    logic [DATA_WIDTH-1:0]     d_req_wdata;
    logic [DATA_WIDTH/8-1:0]   d_req_be;
    logic                      d_req_ready;
    logic                      d_rsp_valid;
    logic [DATA_WIDTH-1:0]     d_rsp_rdata;

    logic                      m_req_valid;
    logic                      m_req_we;
    logic [ADDR_WIDTH-1:0]     m_req_addr;
    logic [DATA_WIDTH-1:0]     m_req_wdata;
    logic [DATA_WIDTH/8-1:0]   m_req_be;
    logic                      m_req_ready;
    logic                      m_rsp_valid;
    logic [DATA_WIDTH-1:0]     m_rsp_rdata;

    logic                      err_spurious;
    arb_state_t                dbg_state;

    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_rsp_valid, i_rsp_rdata,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_be,
        output d_req_ready, d_rsp_valid, d_rsp_rdata,
        output m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_be,
        input  m_req_ready, m_rsp_valid, m_rsp_rdata,
        output err_spurious, dbg_state
    );

    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_rsp_valid, i_rsp_rdata,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_be,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata,
        input  m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_be,
        output m_req_ready, m_rsp_valid, m_rsp_rdata,
        input  err_spurious, dbg_state
    );

endinterface

// File: rtl/mem_arb_grant.sv
// Winner select between fetch and load/store, with a bounded D-priority streak
// so a steady stream of loads/stores cannot starve instruction fetch forever.
module mem_arb_grant
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_grant_en,
    input  logic       i_fetch_valid,
    input  logic       i_lsu_valid,
    output arb_owner_t o_winner
);

    localparam int SW = streak_width(MAX_D_STREAK);
    localparam logic [SW-1:0] SAT = (MAX_D_STREAK > 0) ? SW'(MAX_D_STREAK) : {SW{1'b1}};

    logic [SW-1:0] r_streak;
    logic          w_fetch_turn;

    always_comb begin
        w_fetch_turn = (MAX_D_STREAK != 0) && (r_streak == SAT);
        o_winner     = ARB_OWNER_I;
        if (i_lsu_valid && !(i_fetch_valid && w_fetch_turn)) begin
            o_winner = ARB_OWNER_D;
        end
    end

    // Only D grants that made fetch wait extend the streak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_streak <= '0;
        end else if (i_grant_en) begin
            if (o_winner == ARB_OWNER_D && i_fetch_valid) begin
                r_streak <= (r_streak == SAT) ? r_streak : r_streak + 1'b1;
            end else begin
                r_streak <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store with a single
// outstanding transaction: IDLE grants and latches, ISSUE drives memory, WAIT routes the reply.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);

    localparam int BW = DATA_WIDTH / 8;

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    arb_owner_t              r_owner;
    arb_owner_t              w_winner;
    logic                    r_m_we;
    logic [ADDR_WIDTH-1:0]   r_m_addr;
    logic [DATA_WIDTH-1:0]   r_m_wdata;
    logic [BW-1:0]           r_m_be;
    logic                    r_err_spurious;
    logic                    w_grant_en;
    logic                    w_rsp_fire;

    // Gating with rst_n keeps ready low while reset is held, even with requests pending.
    assign w_grant_en = rst_n && (r_state == ARB_IDLE) && (bus.i_req_valid || bus.d_req_valid);
    assign w_rsp_fire = (r_state == ARB_WAIT) && bus.m_rsp_valid;

    mem_arb_grant #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_grant (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_grant_en    (w_grant_en),
        .i_fetch_valid (bus.i_req_valid),
        .i_lsu_valid   (bus.d_req_valid),
        .o_winner      (w_winner)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE:  if (w_grant_en)      w_state_nxt = ARB_ISSUE;
            ARB_ISSUE: if (bus.m_req_ready) w_state_nxt = ARB_WAIT;
            ARB_WAIT:  if (bus.m_rsp_valid) w_state_nxt = ARB_IDLE;
            default:                        w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ARB_IDLE;
            r_err_spurious <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_err_spurious <= bus.m_rsp_valid && (r_state != ARB_WAIT);
        end
    end

    // Fetches are issued as full-word reads so memory only ever sees one request shape.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner   <= ARB_OWNER_I;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_be    <= '0;
        end else if (w_grant_en) begin
            r_owner <= w_winner;
            if (w_winner == ARB_OWNER_D) begin
                r_m_we    <= bus.d_req_we;
                r_m_addr  <= bus.d_req_addr;
                r_m_wdata <= bus.d_req_wdata;
                r_m_be    <= bus.d_req_be;
            end else begin
                r_m_we    <= 1'b0;
                r_m_addr  <= bus.i_req_addr;
                r_m_wdata <= '0;
                r_m_be    <= '1;
            end
        end
    end

    assign bus.i_req_ready  = w_grant_en && (w_winner == ARB_OWNER_I);
    assign bus.d_req_ready  = w_grant_en && (w_winner == ARB_OWNER_D);

    assign bus.m_req_valid  = (r_state == ARB_ISSUE);
    assign bus.m_req_we     = r_m_we;
    assign bus.m_req_addr   = r_m_addr;
    assign bus.m_req_wdata  = r_m_wdata;
    assign bus.m_req_be     = r_m_be;

    assign bus.i_rsp_valid  = w_rsp_fire && (r_owner == ARB_OWNER_I);
    assign bus.d_rsp_valid  = w_rsp_fire && (r_owner == ARB_OWNER_D);
    assign bus.i_rsp_rdata  = bus.i_rsp_valid ? bus.m_rsp_rdata : '0;
    assign bus.d_rsp_rdata  = bus.d_rsp_valid ? bus.m_rsp_rdata : '0;

    assign bus.err_spurious = r_err_spurious;
    assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level grant/response model.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_D_STREAK(MAXS)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_D_STREAK(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  int checks = 0;
  int failures = 0;
  int m_streak = 0;
  bit spur_prev = 1'b0;
  logic [DW-1:0] exp_q[$];

  task automatic drive_idle();
    bus.i_req_valid = 1'b0;
    bus.i_req_addr  = '0;
    bus.d_req_valid = 1'b0;
    bus.d_req_we    = 1'b0;
    bus.d_req_addr  = '0;
    bus.d_req_wdata = '0;
    bus.d_req_be    = '0;
    bus.m_req_ready = 1'b0;
    bus.m_rsp_valid = 1'b0;
    bus.m_rsp_rdata = '0;
  endtask

  task automatic drive_idle0();
    bus0.i_req_valid = 1'b0;
    bus0.i_req_addr  = '0;
    bus0.d_req_valid = 1'b0;
    bus0.d_req_we    = 1'b0;
    bus0.d_req_addr  = '0;
    bus0.d_req_wdata = '0;
    bus0.d_req_be    = '0;
    bus0.m_req_ready = 1'b0;
    bus0.m_rsp_valid = 1'b0;
    bus0.m_rsp_rdata = '0;
  endtask

  // One full transaction on the main DUT, starting at a negedge with the arbiter idle.
  task automatic run_txn(input bit iv, input bit dv, input logic dwe,
                         input logic [AW-1:0] iaddr, input logic [AW-1:0] daddr,
                         input logic [DW-1:0] dwdata, input logic [BW-1:0] dbe,
                         input int k, input int r, input logic [DW-1:0] rdata,
                         input bit spur_issue, output bit got_d);
    bit exp_d;
    bit last;
    logic e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [BW-1:0] e_be;
    logic [DW-1:0] e_data;

    bus.i_req_valid = iv;
    bus.i_req_addr  = iaddr;
    bus.d_req_valid = dv;
    bus.d_req_we    = dwe;
    bus.d_req_addr  = daddr;
    bus.d_req_wdata = dwdata;
    bus.d_req_be    = dbe;
    bus.m_req_ready = 1'b0;
    bus.m_rsp_valid = 1'b0;
    bus.m_rsp_rdata = $urandom;
    exp_d = dv && !(iv && (MAXS != 0) && (m_streak == MAXS));
    #1;
    got_d = bus.d_req_ready;
    checks++;
    if ({bus.i_req_ready, bus.d_req_ready, bus.m_req_valid, bus.err_spurious} !==
        {iv && !exp_d, exp_d, 1'b0, spur_prev}) begin
      failures++;
      $display("FAIL accept: got i_rdy/d_rdy/m_vld/err=%b%b%b%b exp %b%b%b%b",
               bus.i_req_ready, bus.d_req_ready, bus.m_req_valid, bus.err_spurious,
               iv && !exp_d, exp_d, 1'b0, spur_prev);
    end
    spur_prev = 1'b0;
    if (exp_d && iv) m_streak = (m_streak >= MAXS) ? MAXS : m_streak + 1;
    else             m_streak = 0;
    e_we    = exp_d ? dwe : 1'b0;
    e_addr  = exp_d ? daddr : iaddr;
    e_wdata = exp_d ? dwdata : '0;
    e_be    = exp_d ? dbe : '1;
    exp_q.push_back(rdata);
    @(negedge clk);

    for (int j = 0; j <= k; j++) begin
      bus.i_req_valid = 1'($urandom);
      bus.d_req_valid = 1'($urandom);
      bus.i_req_addr  = $urandom;
      bus.d_req_addr  = $urandom;
      bus.d_req_wdata = $urandom;
      bus.d_req_we    = 1'($urandom);
      bus.d_req_be    = BW'($urandom);
      bus.m_req_ready = (j == k);
      bus.m_rsp_valid = spur_issue && (j == k);
      bus.m_rsp_rdata = $urandom;
      #1;
      checks++;
      if ({bus.i_req_ready, bus.d_req_ready, bus.m_req_valid, bus.i_rsp_valid,
           bus.d_rsp_valid, bus.err_spurious} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, spur_prev}) begin
        failures++;
        $display("FAIL issue_ctrl[%0d]: got rdy_i/rdy_d/m_vld/rsp_i/rsp_d/err=%b%b%b%b%b%b exp 001 00%b",
                 j, bus.i_req_ready, bus.d_req_ready, bus.m_req_valid, bus.i_rsp_valid,
                 bus.d_rsp_valid, bus.err_spurious, spur_prev);
      end
      checks++;
      if ({bus.m_req_we, bus.m_req_addr, bus.m_req_wdata, bus.m_req_be} !==
          {e_we, e_addr, e_wdata, e_be}) begin
        failures++;
        $display("FAIL issue_payload[%0d]: got we=%b addr=%h wdata=%h be=%b exp we=%b addr=%h wdata=%h be=%b",
                 j, bus.m_req_we, bus.m_req_addr, bus.m_req_wdata, bus.m_req_be,
                 e_we, e_addr, e_wdata, e_be);
      end
      spur_prev = spur_issue && (j == k);
      @(negedge clk);
    end

    for (int j = 0; j < r; j++) begin
      last = (j == r - 1);
      bus.i_req_valid = 1'($urandom);
      bus.d_req_valid = 1'($urandom);
      bus.m_req_ready = 1'($urandom);
      bus.m_rsp_valid = last;
      e_data = '0;
      if (last) e_data = exp_q.pop_front();
      bus.m_rsp_rdata = last ? e_data : $urandom;
      #1;
      checks++;
      if ({bus.i_req_ready, bus.d_req_ready, bus.m_req_valid, bus.i_rsp_valid,
           bus.d_rsp_valid, bus.err_spurious} !==
          {1'b0, 1'b0, 1'b0, last && !exp_d, last && exp_d, spur_prev}) begin
        failures++;
        $display("FAIL wait_ctrl[%0d]: got rdy_i/rdy_d/m_vld/rsp_i/rsp_d/err=%b%b%b%b%b%b exp 000%b%b%b",
                 j, bus.i_req_ready, bus.d_req_ready, bus.m_req_valid, bus.i_rsp_valid,
                 bus.d_rsp_valid, bus.err_spurious, last && !exp_d, last && exp_d, spur_prev);
      end
      checks++;
      if ({bus.i_rsp_rdata, bus.d_rsp_rdata} !==
          {(last && !exp_d) ? e_data : DW'(0), (last && exp_d) ? e_data : DW'(0)}) begin
        failures++;
        $display("FAIL wait_rdata[%0d]: got i=%h d=%h exp data %h to %s",
                 j, bus.i_rsp_rdata, bus.d_rsp_rdata, e_data, exp_d ? "D" : "I");
      end
      spur_prev = 1'b0;
      @(negedge clk);
    end
    drive_idle();
  endtask

  task automatic test_reset();
    bit g;
    rst_n = 1'b0;
    drive_idle();
    drive_idle0();
    bus.i_req_valid = 1'b1;
    bus.d_req_valid = 1'b1;
    bus.m_rsp_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.i_req_ready, bus.d_req_ready, bus.i_rsp_valid, bus.d_rsp_valid, bus.m_req_valid,
         bus.m_req_we, bus.m_req_addr, bus.m_req_wdata, bus.m_req_be, bus.i_rsp_rdata,
         bus.d_rsp_rdata, bus.err_spurious} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: nonzero output in reset (addr=%h be=%b rdy=%b%b)",
               bus.m_req_addr, bus.m_req_be, bus.i_req_ready, bus.d_req_ready);
    end
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    @(negedge clk);

    // Load accepted, issued, now waiting; then reset hits mid-WAIT.
    bus.d_req_valid = 1'b1;
    bus.d_req_addr  = 32'h0000_0040;
    @(negedge clk);
    bus.d_req_valid = 1'b0;
    bus.m_req_ready = 1'b1;
    @(negedge clk);
    bus.m_req_ready = 1'b0;
    bus.i_req_valid = 1'b1;
    bus.d_req_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.i_req_ready, bus.d_req_ready, bus.i_rsp_valid, bus.d_rsp_valid, bus.m_req_valid,
         bus.m_req_addr, bus.m_req_be, bus.d_rsp_rdata, bus.err_spurious} !== '0) begin
      failures++;
      $display("FAIL reset_mid_wait: got m_vld=%b addr=%h rdy=%b%b rsp=%b%b exp all 0",
               bus.m_req_valid, bus.m_req_addr, bus.i_req_ready, bus.d_req_ready,
               bus.i_rsp_valid, bus.d_rsp_valid);
    end
    m_streak = 0;
    spur_prev = 1'b0;
    exp_q.delete();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    bus.m_rsp_valid = 1'b1;
    bus.m_rsp_rdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if ({bus.i_rsp_valid, bus.d_rsp_valid, bus.d_rsp_rdata} !== '0) begin
      failures++;
      $display("FAIL late_rsp_dropped: got rsp_i=%b rsp_d=%b d_rdata=%h exp 0",
               bus.i_rsp_valid, bus.d_rsp_valid, bus.d_rsp_rdata);
    end
    @(negedge clk);
    bus.m_rsp_valid = 1'b0;
    #1;
    checks++;
    if ({bus.err_spurious, bus.m_req_valid} !== 2'b10) begin
      failures++;
      $display("FAIL late_rsp_flag: got err=%b m_vld=%b exp err=1 m_vld=0",
               bus.err_spurious, bus.m_req_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.err_spurious !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse_width: got err=%b exp 0", bus.err_spurious);
    end
    @(negedge clk);
    g = 1'b0;
  endtask

  task automatic test_fetch_only();
    bit g;
    run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0010, '0, '0, '0, 0, 1, 32'h00A0_0093, 1'b0, g);
  endtask

  task automatic test_both_store_first();
    bit g;
    run_txn(1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011,
            0, 1, 32'h0000_0000, 1'b0, g);
    checks++;
    if (g !== 1'b1) begin
      failures++;
      $display("FAIL store_first: got d_granted=%b exp 1", g);
    end
    run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0020, '0, '0, '0, 0, 1, 32'h0000_0013, 1'b0, g);
  endtask

  task automatic test_streak();
    bit g;
    logic [5:0] seq;
    seq = '0;
    for (int n = 0; n < 6; n++) begin
      run_txn(1'b1, 1'b1, 1'b0, 32'h0000_1000 + 32'(n * 4), 32'h0000_2000 + 32'(n * 4),
              '0, 4'hF, 0, 1, $urandom, 1'b0, g);
      seq[5 - n] = g;
    end
    checks++;
    if (seq !== 6'b110110) begin
      failures++;
      $display("FAIL streak_pattern: got D-grant sequence %b exp 110110", seq);
    end
  endtask

  task automatic test_mem_stall();
    bit g;
    run_txn(1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0304, 32'h5555_AAAA, 4'b1100,
            3, 2, 32'h0000_0001, 1'b0, g);
  endtask

  task automatic test_load_route();
    bit g;
    run_txn(1'b0, 1'b1, 1'b0, '0, 32'h0000_0200, '0, 4'hF, 0, 1, 32'h1234_5678, 1'b0, g);
  endtask

  task automatic test_spurious();
    bit g;
    bus.m_rsp_valid = 1'b1;
    bus.m_rsp_rdata = 32'hBAD0_BAD0;
    #1;
    checks++;
    if ({bus.i_rsp_valid, bus.d_rsp_valid, bus.i_rsp_rdata, bus.d_rsp_rdata, bus.m_req_valid} !== '0) begin
      failures++;
      $display("FAIL idle_rsp_dropped: got rsp_i=%b rsp_d=%b m_vld=%b exp 0",
               bus.i_rsp_valid, bus.d_rsp_valid, bus.m_req_valid);
    end
    spur_prev = 1'b1;
    @(negedge clk);
    bus.m_rsp_valid = 1'b0;
    run_txn(1'b0, 1'b1, 1'b1, '0, 32'h0000_0400, 32'h0F0F_0F0F, 4'b0101, 1, 1, 32'h0, 1'b1, g);
  endtask

  task automatic test_random();
    bit g;
    bit iv;
    bit dv;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        drive_idle();
        #1;
        checks++;
        if ({bus.i_req_ready, bus.d_req_ready, bus.m_req_valid, bus.i_rsp_valid,
             bus.d_rsp_valid, bus.err_spurious} !== {5'b0, spur_prev}) begin
          failures++;
          $display("FAIL rand_idle[%0d]: got rdy/m_vld/rsp=%b%b%b%b%b err=%b exp 0 err=%b", n,
                   bus.i_req_ready, bus.d_req_ready, bus.m_req_valid, bus.i_rsp_valid,
                   bus.d_rsp_valid, bus.err_spurious, spur_prev);
        end
        spur_prev = 1'b0;
        @(negedge clk);
      end
      iv = 1'($urandom);
      dv = 1'($urandom);
      if (!iv && !dv) iv = 1'b1;
      run_txn(iv, dv, 1'($urandom), $urandom, $urandom, $urandom, BW'($urandom),
              $urandom_range(0, 3), $urandom_range(1, 3), $urandom,
              $urandom_range(0, 7) == 0, g);
    end
  endtask

  // MAX_D_STREAK=0 instance: zero-wait memory, both requesters held, D always wins.
  task automatic test_d_priority();
    drive_idle0();
    bus0.i_req_valid = 1'b1;
    bus0.i_req_addr  = 32'h0000_0800;
    bus0.d_req_valid = 1'b1;
    bus0.d_req_addr  = 32'h0000_0900;
    bus0.m_req_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      bus0.m_rsp_valid = (c % 3 == 2);
      bus0.m_rsp_rdata = 32'h0000_0900 + 32'(c);
      #1;
      checks++;
      if ({bus0.i_req_ready, bus0.d_req_ready, bus0.i_rsp_valid, bus0.d_rsp_valid} !==
          {1'b0, c % 3 == 0, 1'b0, c % 3 == 2}) begin
        failures++;
        $display("FAIL d_priority[%0d]: got rdy_i/rdy_d/rsp_i/rsp_d=%b%b%b%b exp 0%b0%b", c,
                 bus0.i_req_ready, bus0.d_req_ready, bus0.i_rsp_valid, bus0.d_rsp_valid,
                 c % 3 == 0, c % 3 == 2);
      end
      @(negedge clk);
    end
    drive_idle0();
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_both_store_first();
    test_streak();
    test_mem_stall();
    test_load_route();
    test_spurious();
    test_random();
    test_d_priority();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
